// File: rtl/timer_sequencer.sv
// Interval feeder for the down-counting timer: queues intervals, loads them one at a
// time, paces the countdown with a prescaled enable and advances on trigger.
module timer_sequencer #(
   parameter int WIDTH    = 5,
   parameter int DEPTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_value,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     start,
   input  logic                     stop,
   output logic [WIDTH-1:0]         value,
   output logic                     valid,
   output logic                     enable,
   input  logic                     trigger,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy,
   output logic                     done
);

   // state | meaning
   // IDLE  | waiting for start with a non-empty queue
   // LOAD  | drive head interval with valid, pop it
   // ARM   | timer registers the value, prescaler cleared
   // RUN   | prescaled enable ticks until trigger
   typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   state_t             state, state_next;
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]      rd_ptr, wr_ptr;
   logic [AW:0]        count;
   logic [PW-1:0]      presc;
   logic [WIDTH-1:0]   last_value;
   logic               push, pop;

   // zero intervals complete the handshake but are dropped
   assign in_ready = (count != FULL_LEVEL);
   assign push     = in_valid && in_ready && (in_value != '0);
   assign pop      = (state == LOAD);
   assign level    = count;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_value;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         last_value <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            last_value <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || state != RUN) presc <= '0;
      else if (presc == PRESC_LAST) presc <= '0;
      else presc <= presc + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start && count != '0) state_next = LOAD;
         LOAD: state_next = stop ? IDLE : ARM;
         ARM:  state_next = stop ? IDLE : RUN;
         RUN: begin
            if (stop)         state_next = IDLE;
            else if (trigger) state_next = (count != '0) ? LOAD : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      valid  = (state == LOAD);
      value  = (state == LOAD) ? mem[rd_ptr] : last_value;
      enable = (state == RUN) && (presc == PRESC_LAST) && !trigger;
      done   = (state == RUN) && trigger && !stop && (count == '0);
      busy   = (state != IDLE);
   end

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a queue/age based model of the sequencing rules.
module tb_timer_sequencer;
   localparam int W = 5;
   localparam int D = 4;
   localparam int P = 4;

   logic           clk = 0;
   logic           reset = 1;
   logic [W-1:0]   in_value = '0;
   logic           in_valid = 0;
   logic           in_ready;
   logic           start = 0;
   logic           stop = 0;
   logic [W-1:0]   value;
   logic           valid;
   logic           enable;
   logic           trigger = 0;
   logic [2:0]     level;
   logic           busy;
   logic           done;

   timer_sequencer #(.WIDTH(W), .DEPTH(D), .PRESCALE(P)) dut (
      .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
      .in_ready(in_ready), .start(start), .stop(stop), .value(value),
      .valid(valid), .enable(enable), .trigger(trigger), .level(level),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;

   // model: pending intervals, whether playing, cycles since the current load
   logic [W-1:0] q[$];
   bit           active = 0;
   int           age = 0;
   logic [W-1:0] last = '0;
   int           lvl0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         active = 0;
         age = 0;
         last = '0;
      end else begin
         lvl0 = q.size();
         if (active && age == 0) begin
            last = q[0];
            void'(q.pop_front());
         end
         if (in_valid && lvl0 != D && in_value != 0) q.push_back(in_value);
         if (!active) begin
            if (start && lvl0 != 0) begin
               active = 1;
               age = 0;
            end
         end else if (stop) begin
            active = 0;
         end else if (age >= 2 && trigger) begin
            if (lvl0 != 0) age = 0;
            else active = 0;
         end else begin
            age++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit ld, run;
         ld  = active && age == 0;
         run = active && age >= 2;
         chk("in_ready", in_ready, q.size() != D);
         chk("level", level, q.size());
         chk("busy", busy, active);
         chk("valid", valid, ld);
         chk("value", value, ld ? q[0] : last);
         chk("enable", enable, run && ((age - 1) % P == 0) && !trigger);
         chk("done", done, run && trigger && !stop && q.size() == 0);
      end
   end

   task automatic drive(input logic r, input logic iv, input logic [W-1:0] v,
                        input logic st, input logic sp, input logic tr);
      @(posedge clk);
      #1;
      reset = r; in_valid = iv; in_value = v; start = st; stop = sp; trigger = tr;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      chk_en = 1;
      drive(1, 0, 0, 0, 0, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_value", value, 0);

      // push 3,5 then play both
      drive(0, 1, 3, 0, 0, 0);
      drive(0, 1, 5, 0, 0, 0);
      idle();
      chk("s1_level", level, 2);
      chk("s1_in_ready", in_ready, 1);
      drive(0, 0, 0, 1, 0, 0);
      idle();
      chk("s1_load_valid", valid, 1);
      chk("s1_load_value", value, 3);
      idle();
      chk("s1_arm_valid", valid, 0);
      idle();
      chk("s1_run0_enable", enable, 0);
      idle();
      idle();
      idle();
      chk("s1_run3_enable", enable, 1);
      drive(0, 0, 0, 0, 0, 1);
      chk("s1_trig_done", done, 0);
      idle();
      chk("s1_load2_value", value, 5);
      idle();
      drive(0, 0, 0, 0, 0, 1);
      chk("s1_last_done", done, 1);
      idle();
      chk("s1_after_busy", busy, 0);
      chk("s1_after_done", done, 0);

      // full FIFO refuses a push
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) drive(0, 1, W'(i), 0, 0, 0);
      drive(0, 1, 7, 0, 0, 0);
      chk("s2_full_ready", in_ready, 0);
      chk("s2_full_level", level, 4);
      idle();
      chk("s2_level_kept", level, 4);
      drive(0, 0, 0, 1, 0, 0);
      idle();
      chk("s2_load_value", value, 1);
      idle();
      chk("s2_pop_level", level, 3);
      chk("s2_pop_ready", in_ready, 1);
      drive(0, 0, 0, 0, 1, 0);
      idle();
      chk("s2_stop_busy", busy, 0);

      // zero interval discarded
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      chk("s3_zero_ready", in_ready, 1);
      drive(0, 1, 6, 0, 0, 0);
      idle();
      chk("s3_level", level, 1);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 1, 0);
      chk("s3_load_value", value, 6);
      idle();
      chk("s3_stop_level", level, 0);

      // 2,2 with two triggers
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 2, 0, 0, 0);
      drive(0, 1, 2, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      idle(); idle(); idle();
      drive(0, 0, 0, 0, 0, 1);
      idle();
      chk("s4_load2_valid", valid, 1);
      chk("s4_load2_value", value, 2);
      idle(); idle(); idle();
      drive(0, 0, 0, 0, 0, 1);
      chk("s4_done", done, 1);
      idle();
      chk("s4_level", level, 0);
      chk("s4_busy", busy, 0);

      // stop beats trigger
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 4, 0, 0, 0);
      drive(0, 1, 4, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      idle(); idle(); idle(); idle(); idle();
      drive(0, 0, 0, 0, 1, 1);
      chk("s5_done", done, 0);
      chk("s5_enable", enable, 0);
      idle();
      chk("s5_busy", busy, 0);
      chk("s5_level", level, 1);

      // reset during ARM
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 9, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      idle();
      drive(1, 0, 0, 0, 0, 0);
      idle();
      chk("s6_busy", busy, 0);
      chk("s6_level", level, 0);
      chk("s6_value", value, 0);
      chk("s6_valid", valid, 0);
      chk("s6_enable", enable, 0);
      drive(0, 0, 0, 1, 0, 0);
      idle();
      chk("s6_empty_start", busy, 0);

      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] v;
         v = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 31));
         drive($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), v,
               $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 7) == 0);
      end

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Upstream feeder for the 5-bit down-counting timer.
- Buffers a queue of interval values pushed by a producer over a valid/ready handshake.
- Loads each interval into the timer (value/valid), paces the countdown with a prescaled enable tick, and advances to the next interval when the timer raises trigger.
- Reports a one-cycle done pulse when the queue has been fully played out.

Parameters:
WIDTH, 5, bit width of interval values; matches timer value/count width
DEPTH, 4, interval FIFO entries (power of two, >=2)
PRESCALE, 4, clk cycles per enable tick while running (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_value  input  WIDTH  interval to enqueue
in_valid  input  1  producer offers in_value this cycle
in_ready  output  1  FIFO can accept; equals !full
start  input  1  begin playing queued intervals (sampled in IDLE only)
stop  input  1  abort playback, return to IDLE; FIFO contents retained
value  output  WIDTH  interval driven to the timer
valid  output  1  one-cycle load strobe to the timer
enable  output  1  countdown tick to the timer
trigger  input  1  timer expiry pulse
level  output  clog2(DEPTH)+1  FIFO occupancy
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when the last interval expires

Behaviour:
- All state updates occur on the rising clk edge. Reset is synchronous and active-high and has priority over every other input.
- Reset values: FIFO empty, level=0, state IDLE, value=0, valid=0, enable=0, busy=0, done=0, prescaler=0. in_ready=1 once reset deasserts.
- Push: occurs when in_valid && in_ready. An in_value of 0 completes the handshake but is discarded (not stored, level unchanged).
- in_ready = (level != DEPTH). in_ready does not look ahead to a same-cycle pop, so a full FIFO refuses a push even in a cycle when it pops.
- Pop: occurs only in LOAD. Simultaneous push and pop leaves level unchanged. Read/write pointers wrap modulo DEPTH.
- States: IDLE, LOAD, ARM, RUN.
- IDLE: if start && level!=0, go to LOAD next cycle. If start && level==0, stay in IDLE (no done pulse).
- LOAD, 1 cycle: valid=1, value=FIFO head; pop the head; go to ARM.
- ARM, 1 cycle: valid=0, which gives the timer one cycle to register the value. Clear the prescaler to 0; go to RUN.
- RUN: the prescaler counts 0..PRESCALE-1 and wraps. enable=1 exactly in cycles where prescaler==PRESCALE-1 (every cycle if PRESCALE=1).
- RUN exit on trigger=1: go to LOAD if level!=0, else go to IDLE and pulse done=1 in that same cycle. enable is forced to 0 in the trigger cycle.
- trigger is ignored outside RUN.
- stop: from LOAD, ARM or RUN, go to IDLE next cycle. No done pulse, no pop (a LOAD cycle coinciding with stop still pops), enable=0 and valid=0 from the next cycle. stop takes priority over trigger in the same cycle.
- value holds the last loaded interval until the next LOAD or reset.
- busy = (state != IDLE).
- Reset mid-playback: state returns to IDLE and the FIFO is flushed (level=0) on the reset edge.
- Interval latency: an interval N loaded in cycle t sees its first enable at t+1+PRESCALE (ARM at t+1, RUN from t+2).

Test Plan:
- Reset, then push 3,5 (PRESCALE=4): level=2, in_ready=1 → start → LOAD with value=3, valid=1 for exactly 1 cycle; enable pulses every 4th cycle in RUN.
- Fill DEPTH=4 with 1,2,3,4, then offer 7: in_ready=0, 7 is not stored, level stays 4; pop during playback → level=3, in_ready=1.
- Push 0 then 6: both handshakes complete, level=1, the only loaded value is 6.
- Queue 2,2, start, drive trigger in RUN twice: first trigger → LOAD of second 2; second trigger → IDLE, done=1 for 1 cycle, busy=0, level=0.
- stop and trigger asserted together in RUN with level=1: next state IDLE, done=0, level stays 1, enable=0.
- Push 9, start, assert reset during ARM: next cycle state IDLE, level=0, value=0, valid=0, enable=0; start with empty FIFO afterwards → remains IDLE.
